bitwise_frame_accum: RTL and testbench

- Parametrised streaming successor to the fixed 16-bit bitwise gate arrays.
- Applies a selectable bitwise op (OR/AND/XOR/XNOR) to two WIDTH-bit operands each beat.
- Folds the per-beat results across a multi-beat frame into one registered word, with a valid/ready handshake on both sides.
- Sits between the ALU datapath and the I/O/flag logic, for frame-level masks, for example "any bit set across N words".

---
 rtl/bitwise_frame_accum.sv | 125 ++++++++++++
 tb/tb_bitwise_frame_accum.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bitwise_frame_accum.sv
// rtl/bitwise_frame_accum.sv - folds per-beat bitwise ops (OR/AND/XOR/XNOR) across a frame into one handshaked result word
module bitwise_frame_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CNT_W-1:0] out_count,
  output logic             restart_err
);

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      default: res = a | b;
    endcase
    return res;
  endfunction

  state_e           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_valid;
  logic             r_restart_err;

  logic             w_accept;
  logic             w_start;
  logic             w_restart;
  logic             w_done;
  logic             w_drain;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_beat;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Stall only while a finished result is blocked; this also stalls non-last beats.
  assign in_ready  = !(r_out_valid && !out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_restart = w_accept && in_first && (r_state == S_ACCUM);
  assign w_start   = w_accept && (in_first || (r_state == S_IDLE));
  assign w_done    = w_accept && in_last;
  assign w_drain   = r_out_valid && out_ready;

  assign w_op   = w_start ? in_op : r_op;
  assign w_beat = apply_op(w_op, in_x, in_y);

  assign w_acc_next = w_start ? w_beat : apply_op(r_op, r_acc, w_beat);
  assign w_cnt_next = w_start ? CNT_ONE :
                      (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_OR;
      r_acc         <= '0;
      r_count       <= '0;
      r_out_data    <= '0;
      r_out_count   <= '0;
      r_out_valid   <= 1'b0;
      r_restart_err <= 1'b0;
    end else begin
      r_restart_err <= w_restart;

      if (w_accept) begin
        r_acc   <= w_acc_next;
        r_count <= w_cnt_next;
        if (w_start) begin
          r_op <= in_op;
        end
        r_state <= w_done ? S_IDLE : S_ACCUM;
      end

      // A completion on the draining edge takes priority so the slot stays full.
      if (w_done) begin
        r_out_data  <= w_acc_next;
        r_out_count <= w_cnt_next;
        r_out_valid <= 1'b1;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_count   = r_out_count;
  assign out_any     = |r_out_data;
  assign restart_err = r_restart_err;

endmodule

// File: tb/tb_bitwise_frame_accum.sv
// tb/tb_bitwise_frame_accum.sv - directed self-checking bench for bitwise_frame_accum
module tb_bitwise_frame_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic [1:0]  in_op = 2'b00;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_any;
  logic [7:0]  out_count;
  logic        restart_err;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_any;
  logic [1:0]  s_out_count;
  logic        s_restart_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bitwise_frame_accum #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_any(out_any), .out_count(out_count), .restart_err(restart_err)
  );

  // Narrow-counter twin driven in lockstep, used for the saturation check.
  bitwise_frame_accum #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op), .in_first(in_first), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_any(s_out_any), .out_count(s_out_count), .restart_err(s_restart_err)
  );

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op,
                      input logic f, input logic l);
    int k;
    in_x = x; in_y = y; in_op = op; in_first = f; in_last = l; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_tests++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_tests++; if (restart_err !== 1'b0) begin n_fail++; $display("FAIL reset_rerr: got %0b want 0", restart_err); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single;
    send(16'h00F0, 16'h0F00, 2'b00, 1'b1, 1'b1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_tests++; if (out_data !== 16'h0FF0) begin n_fail++; $display("FAIL single_data: got %h want 0ff0", out_data); end
    n_tests++; if (out_count !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_count); end
    n_tests++; if (out_any !== 1'b1) begin n_fail++; $display("FAIL single_any: got %0b want 1", out_any); end
  endtask

  task automatic test_or_frame;
    send(16'h0001, 16'h0000, 2'b00, 1'b1, 1'b0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL or_drained: got %0b want 0", out_valid); end
    send(16'h0000, 16'h0100, 2'b01, 1'b0, 1'b0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL or_midframe_valid: got %0b want 0", out_valid); end
    send(16'h8000, 16'h0000, 2'b01, 1'b0, 1'b1);
    n_tests++; if (out_data !== 16'h8101) begin n_fail++; $display("FAIL or_data: got %h want 8101", out_data); end
    n_tests++; if (out_count !== 8'd3) begin n_fail++; $display("FAIL or_count: got %0d want 3", out_count); end
  endtask

  task automatic test_and_zero;
    send(16'hFFFF, 16'hFFF0, 2'b01, 1'b1, 1'b0);
    send(16'h000F, 16'hFFFF, 2'b00, 1'b0, 1'b1);
    n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL and_data: got %h want 0000", out_data); end
    n_tests++; if (out_any !== 1'b0) begin n_fail++; $display("FAIL and_any: got %0b want 0", out_any); end
    n_tests++; if (out_count !== 8'd2) begin n_fail++; $display("FAIL and_count: got %0d want 2", out_count); end
  endtask

  task automatic test_backpressure;
    send(16'h1234, 16'h00FF, 2'b10, 1'b1, 1'b1);
    out_ready = 1'b0;
    in_x = 16'hF0F0; in_y = 16'hFF00; in_op = 2'b01; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_data !== 16'h12CB) begin n_fail++; $display("FAIL bp_hold_data: got %h want 12cb", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %0b want 1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    n_tests++; if (out_data !== 16'hF000) begin n_fail++; $display("FAIL bp_second_data: got %h want f000", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %0b want 1", out_valid); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_restart;
    send(16'h0003, 16'h0000, 2'b00, 1'b1, 1'b0);
    n_tests++; if (restart_err !== 1'b0) begin n_fail++; $display("FAIL rs_quiet: got %0b want 0", restart_err); end
    send(16'h00FF, 16'h0F0F, 2'b11, 1'b1, 1'b0);
    n_tests++; if (restart_err !== 1'b1) begin n_fail++; $display("FAIL rs_pulse: got %0b want 1", restart_err); end
    send(16'hFFFF, 16'h0000, 2'b00, 1'b0, 1'b1);
    n_tests++; if (restart_err !== 1'b0) begin n_fail++; $display("FAIL rs_pulse_end: got %0b want 0", restart_err); end
    n_tests++; if (out_data !== 16'h0FF0) begin n_fail++; $display("FAIL rs_data: got %h want 0ff0", out_data); end
    n_tests++; if (out_count !== 8'd2) begin n_fail++; $display("FAIL rs_count: got %0d want 2", out_count); end
  endtask

  task automatic test_back_to_back;
    in_x = 16'h0001; in_y = 16'h0002; in_op = 2'b00; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_data !== 16'h0003) begin n_fail++; $display("FAIL b2b_first: got %h want 0003", out_data); end
    in_x = 16'hFF00; in_y = 16'h0FF0; in_op = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    n_tests++; if (out_data !== 16'h0F00) begin n_fail++; $display("FAIL b2b_second: got %h want 0f00", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 6; i++) begin
      send(16'(1 << i), 16'h0000, 2'b00, i == 0, i == 5);
    end
    n_tests++; if (out_count !== 8'd6) begin n_fail++; $display("FAIL sat_wide_count: got %0d want 6", out_count); end
    n_tests++; if (s_out_count !== 2'd3) begin n_fail++; $display("FAIL sat_narrow_count: got %0d want 3", s_out_count); end
    n_tests++; if (s_out_data !== 16'h003F) begin n_fail++; $display("FAIL sat_narrow_data: got %h want 003f", s_out_data); end
  endtask

  task automatic test_async_reset;
    send(16'h1111, 16'h2222, 2'b00, 1'b1, 1'b1);
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL ar_data: got %h want 0000", out_data); end
    n_tests++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", out_count); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %0b want 1", in_ready); end
    send(16'hFFFF, 16'h0000, 2'b00, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'hAAAA, 16'hFFFF, 2'b10, 1'b0, 1'b1);
    n_tests++; if (out_data !== 16'h5555) begin n_fail++; $display("FAIL ar_xor_data: got %h want 5555", out_data); end
    n_tests++; if (out_count !== 8'd1) begin n_fail++; $display("FAIL ar_xor_count: got %0d want 1", out_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_or_frame();
    test_and_zero();
    test_backpressure();
    test_restart();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
